// File: rtl/lives_ctrl_pkg.sv
// Shared game definitions: life limits, invulnerability default and FSM encoding.
// Also used by the score and sprite blocks.
package lives_ctrl_pkg;

  localparam int MAX_LIVES          = 3;
  localparam int DEFAULT_INV_FRAMES = 120;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_INV  = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  // Lives after an optional accepted hit and optional award, saturated at MAX_LIVES.
  // A hit is only ever applied with lives >= 1, so the 3-bit sum cannot wrap.
  function automatic logic [1:0] lives_update(input logic [1:0] lives,
                                              input logic       hit,
                                              input logic       award);
    logic [2:0] sum;
    sum = {1'b0, lives} + {2'b00, award} - {2'b00, hit};
    if (sum > 3'(MAX_LIVES)) sum = 3'(MAX_LIVES);
    return sum[1:0];
  endfunction

endpackage

// File: rtl/lives_ctrl_if.sv
// Game-side signal bundle for the lives controller.
interface lives_ctrl_if;

  logic       frame_tick;
  logic       player_hit;
  logic [2:0] speed_level;
  logic       restart;
  logic [1:0] p_lives;
  logic       invuln;
  logic       blink;
  logic       life_lost;
  logic       game_over;

  modport master (
    output frame_tick, player_hit, speed_level, restart,
    input  p_lives, invuln, blink, life_lost, game_over
  );

  modport slave (
    input  frame_tick, player_hit, speed_level, restart,
    output p_lives, invuln, blink, life_lost, game_over
  );

endinterface

// File: rtl/lives_ctrl.sv
// Player lives / invulnerability / game-over controller.
// Single registered FSM: PLAY -> INV on a hit, INV -> PLAY after INV_FRAMES frames, OVER on last life.
module lives_ctrl
  import lives_ctrl_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int INV_FRAMES  = DEFAULT_INV_FRAMES,
  parameter int BLINK_BIT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  lives_ctrl_if.slave  bus
);

  localparam logic [1:0] START_LOAD = 2'(START_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);

  game_state_t state_reg;
  logic [7:0]  inv_cnt_reg;
  logic [2:0]  spd_q_reg;
  logic [1:0]  lives_reg;
  logic        invuln_reg;
  logic        blink_reg;
  logic        life_lost_reg;
  logic        game_over_reg;

  logic        award;
  logic [1:0]  lives_hit;
  logic [1:0]  lives_award;
  logic [7:0]  inv_dec;

  // A rising difficulty level earns a life; drops (score reset) are ignored.
  assign award       = (bus.speed_level > spd_q_reg) && (state_reg != ST_OVER);
  assign lives_hit   = lives_update(lives_reg, 1'b1, award);
  assign lives_award = lives_update(lives_reg, 1'b0, award);
  assign inv_dec     = inv_cnt_reg - 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_PLAY;
      lives_reg     <= START_LOAD;
      inv_cnt_reg   <= 8'd0;
      spd_q_reg     <= bus.speed_level;
      invuln_reg    <= 1'b0;
      blink_reg     <= 1'b0;
      life_lost_reg <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      spd_q_reg     <= bus.speed_level;
      life_lost_reg <= 1'b0;
      case (state_reg)
        ST_PLAY: begin
          if (bus.player_hit) begin
            lives_reg     <= lives_hit;
            life_lost_reg <= 1'b1;
            if (lives_hit == 2'd0) begin
              state_reg     <= ST_OVER;
              game_over_reg <= 1'b1;
            end else begin
              state_reg   <= ST_INV;
              inv_cnt_reg <= INV_LOAD;
              invuln_reg  <= 1'b1;
              blink_reg   <= INV_LOAD[BLINK_BIT];
            end
          end else begin
            lives_reg <= lives_award;
          end
        end
        ST_INV: begin
          // Hits are ignored here; awards still apply without touching the counter.
          lives_reg <= lives_award;
          if (bus.frame_tick) begin
            if (inv_cnt_reg == 8'd1) begin
              state_reg   <= ST_PLAY;
              inv_cnt_reg <= 8'd0;
              invuln_reg  <= 1'b0;
              blink_reg   <= 1'b0;
            end else begin
              inv_cnt_reg <= inv_dec;
              blink_reg   <= inv_dec[BLINK_BIT];
            end
          end
        end
        ST_OVER: begin
          if (bus.restart) begin
            state_reg     <= ST_PLAY;
            lives_reg     <= START_LOAD;
            game_over_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_PLAY;
          lives_reg     <= START_LOAD;
          inv_cnt_reg   <= 8'd0;
          invuln_reg    <= 1'b0;
          blink_reg     <= 1'b0;
          game_over_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p_lives   = lives_reg;
  assign bus.invuln    = invuln_reg;
  assign bus.blink     = blink_reg;
  assign bus.life_lost = life_lost_reg;
  assign bus.game_over = game_over_reg;

endmodule
